// File: rtl/mem_arb_pkg.sv
// Shared types for the memory access arbiter: FSM states, the registered
// command record and the read opcode encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_WORD = 2'd0;
    localparam logic [1:0] OP_HALF = 2'd1;
    localparam logic [1:0] OP_BYTE = 2'd2;
    localparam logic [1:0] OP_BIT  = 2'd3;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [1:0]  opcode;
        logic [4:0]  bitaddr;
        logic [1:0]  byteaddr;
    } mem_cmd_t;

endpackage

// File: rtl/mem_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts at ptr and wraps, so the
// requester just after the last owner has highest priority.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          found_s;
    logic [IW-1:0] idx_s;
    int            k;

    // Scan N positions starting at the pointer, first active request wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        idx_s   = '0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            k = (k >= N) ? (k - N) : k;
            idx_s = IW'(k);
            if (!found_s && req[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                gnt_idx    = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin sequencer sharing one memory among NREQ requesters: one command
// in flight, fixed read latency, one-cycle response pulse to the owner.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          NREQ       = 2,
    parameter int          RD_LAT     = 2,
    parameter logic [31:0] STUDENT_ID = 32'd123
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ-1:0][15:0] req_addr,
    input  logic [NREQ-1:0][31:0] req_wdata,
    input  logic [NREQ-1:0][1:0]  req_opcode,
    input  logic [NREQ-1:0][4:0]  req_bitaddr,
    input  logic [NREQ-1:0][1:0]  req_byteaddr,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [15:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [1:0]            mem_opcode,
    output logic [4:0]            mem_bitaddr,
    output logic [1:0]            mem_byteaddr,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           mem_student_id
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(RD_LAT + 1);

    state_t        state_q, state_d;
    mem_cmd_t      cmd_q, cmd_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [NREQ-1:0] gnt_s;
    logic [IW-1:0]   gnt_idx_s;
    logic            active_s;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // State and command registers; reset drops any in-flight command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: accept in IDLE, one WRITE cycle or RD_LAT READ cycles, then RESP
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (|gnt_s) begin
                    cmd_d.we       = req_we[gnt_idx_s];
                    cmd_d.addr     = req_addr[gnt_idx_s];
                    cmd_d.wdata    = req_wdata[gnt_idx_s];
                    cmd_d.opcode   = req_opcode[gnt_idx_s];
                    cmd_d.bitaddr  = req_bitaddr[gnt_idx_s];
                    cmd_d.byteaddr = req_byteaddr[gnt_idx_s];
                    owner_d        = gnt_idx_s;
                    ptr_d          = (gnt_idx_s == IW'(NREQ - 1)) ? '0 : (gnt_idx_s + IW'(1));
                    cnt_d          = '0;
                    state_d        = req_we[gnt_idx_s] ? WRITE : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                rdata_d = 32'h0;
                state_d = RESP;
            end
            READ: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state; the memory bus is zero when idle
    always_comb begin
        active_s       = (state_q == WRITE) || (state_q == READ);
        req_ready      = ((state_q == IDLE) && !reset) ? gnt_s : '0;
        mem_wr_en      = (state_q == WRITE) && cmd_q.we;
        mem_rd_en      = (state_q == READ);
        mem_addr       = active_s ? cmd_q.addr : 16'h0;
        mem_wdata      = (state_q == WRITE) ? cmd_q.wdata : 32'h0;
        mem_opcode     = active_s ? cmd_q.opcode : 2'd0;
        mem_bitaddr    = active_s ? cmd_q.bitaddr : 5'd0;
        mem_byteaddr   = active_s ? cmd_q.byteaddr : 2'd0;
        rsp_valid      = (state_q == RESP) ? (NREQ'(1) << owner_q) : '0;
        rsp_rdata      = (state_q == RESP) ? rdata_q : 32'h0;
        mem_student_id = STUDENT_ID;
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural memory model.
module tb_mem_access_arbiter;

    localparam int NREQ   = 2;
    localparam int RD_LAT = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid, req_ready, req_we, rsp_valid;
    logic [NREQ-1:0][15:0] req_addr;
    logic [NREQ-1:0][31:0] req_wdata;
    logic [NREQ-1:0][1:0]  req_opcode, req_byteaddr;
    logic [NREQ-1:0][4:0]  req_bitaddr;
    logic [31:0]           rsp_rdata, mem_wdata, mem_rdata, mem_student_id;
    logic                  mem_wr_en, mem_rd_en;
    logic [15:0]           mem_addr;
    logic [1:0]            mem_opcode, mem_byteaddr;
    logic [4:0]            mem_bitaddr;

    logic [31:0] mem_model [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT), .STUDENT_ID(32'd123)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_opcode(req_opcode),
        .req_bitaddr(req_bitaddr), .req_byteaddr(req_byteaddr),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_opcode(mem_opcode), .mem_bitaddr(mem_bitaddr),
        .mem_byteaddr(mem_byteaddr), .mem_rdata(mem_rdata), .mem_student_id(mem_student_id)
    );

    always @(posedge clk) begin
        if (mem_wr_en) mem_model[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem_rd_en ? mem_model[mem_addr] : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        req_opcode = '0; req_bitaddr = '0; req_byteaddr = '0;
    endtask

    task automatic set_req(input int r, input logic we, input logic [15:0] a,
                           input logic [31:0] d, input logic [1:0] op);
        req_valid[r]    = 1'b1;
        req_we[r]       = we;
        req_addr[r]     = a;
        req_wdata[r]    = d;
        req_opcode[r]   = op;
        req_bitaddr[r]  = a[4:0];
        req_byteaddr[r] = a[1:0];
    endtask

    task automatic wait_grant(input int r);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            #1;
            if (req_ready[r]) got = 1'b1;
            else tick();
        end
        check("grant_wait", 32'(got), 32'd1);
    endtask

    task automatic do_write(input int r, input logic [15:0] a, input logic [31:0] d);
        set_req(r, 1'b1, a, d, 2'd0);
        wait_grant(r);
        tick();
        req_valid[r] = 1'b0;
        #1;
        check("wr_en", 32'(mem_wr_en), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'(a));
        check("wr_data", mem_wdata, d);
        check("wr_ready_busy", 32'(req_ready), 32'd0);
        tick();
        check("wr_en_one_cycle", 32'(mem_wr_en), 32'd0);
        check("wr_rsp_valid", 32'(rsp_valid), 32'(1 << r));
        check("wr_rsp_rdata", rsp_rdata, 32'h0);
        tick();
    endtask

    task automatic do_read(input int r, input logic [15:0] a, input logic [1:0] op,
                           input logic [31:0] exp);
        set_req(r, 1'b0, a, 32'h0, op);
        wait_grant(r);
        tick();
        req_valid[r] = 1'b0;
        for (int c = 0; c < RD_LAT; c++) begin
            req_addr[r]     = ~a;
            req_opcode[r]   = ~op;
            req_bitaddr[r]  = ~a[4:0];
            req_byteaddr[r] = ~a[1:0];
            #1;
            check("rd_en", 32'(mem_rd_en), 32'd1);
            check("rd_addr_stable", 32'(mem_addr), 32'(a));
            check("rd_op_stable", 32'(mem_opcode), 32'(op));
            check("rd_bit_stable", 32'(mem_bitaddr), 32'(a[4:0]));
            check("rd_byte_stable", 32'(mem_byteaddr), 32'(a[1:0]));
            check("rd_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        check("rd_rsp_valid", 32'(rsp_valid), 32'(1 << r));
        check("rd_rsp_rdata", rsp_rdata, exp);
        check("rd_en_off", 32'(mem_rd_en), 32'd0);
        tick();
    endtask

    initial begin
        logic [15:0] sweep [16];
        int          exp_r, cnt0, cnt1;

        reset = 1'b1;
        clear_reqs();
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("student_id", mem_student_id, 32'd123);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single write then read back by requester 0
        do_write(0, 16'h0010, 32'h0000_0010);
        do_read(0, 16'h0010, 2'd0, 32'h0000_0010);

        // Write ack to requester 1
        do_write(1, 16'h0020, 32'hDEAD_BEEF);

        // Contention: both requesters read continuously, pointer is at 0
        clear_reqs();
        set_req(0, 1'b0, 16'h0010, 32'h0, 2'd1);
        set_req(1, 1'b0, 16'h0020, 32'h0, 2'd2);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            exp_r = i % 2;
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << exp_r));
            if (req_ready[0]) cnt0++;
            if (req_ready[1]) cnt1++;
            tick();
            for (int c = 0; c < RD_LAT; c++) begin
                check("rr_no_rsp", 32'(rsp_valid), 32'd0);
                tick();
            end
            check("rr_rsp_valid", 32'(rsp_valid), 32'(1 << exp_r));
            check("rr_rsp_rdata", rsp_rdata, (exp_r == 0) ? 32'h0000_0010 : 32'hDEAD_BEEF);
            tick();
        end
        check("rr_count0", 32'(cnt0), 32'd4);
        check("rr_count1", 32'(cnt1), 32'd4);
        clear_reqs();

        // Fill sweep over both ends of the address space
        for (int i = 0; i < 8; i++) begin
            sweep[i]     = 16'(i);
            sweep[i + 8] = 16'hFFF8 + 16'(i);
        end
        for (int i = 0; i < 16; i++) do_write(1, sweep[i], {16'h0, sweep[i]});
        for (int i = 0; i < 16; i++) do_read(0, sweep[i], 2'd3, {16'h0, sweep[i]});
        clear_reqs();

        // Reset in first READ cycle: pointer now at 1 after requester 0's read
        do_read(0, 16'h0010, 2'd0, 32'h0000_0010);
        set_req(0, 1'b0, 16'h0020, 32'h0, 2'd2);
        wait_grant(0);
        tick();
        clear_reqs();
        #1;
        check("mid_rd_en", 32'(mem_rd_en), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_opcode", 32'(mem_opcode), 32'd0);
        check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        set_req(1, 1'b0, 16'h0020, 32'h0, 2'd0);
        set_req(0, 1'b0, 16'h0010, 32'h0, 2'd0);
        #1;
        check("post_rst_tie", 32'(req_ready), 32'd1);
        do_read(0, 16'h0010, 2'd0, 32'h0000_0010);
        clear_reqs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
